// File: rtl/div_seq_q.sv
// Sequential radix-2 restoring fixed-point divider: qout = ain * 2^FB / bin.
// Optional signed operands, round-half-up, divide-by-zero and saturating overflow.
module div_seq_q #(
    parameter int AW  = 16,
    parameter int BW  = 16,
    parameter int QW  = 24,
    parameter int FB  = 23,
    parameter int SGN = 0,
    parameter int RND = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ain,
    input  logic [BW-1:0] bin,
    input  logic          iv,
    output logic          rdy,
    output logic [QW-1:0] qout,
    output logic          ov,
    output logic          dz,
    output logic          ovf
);
    localparam int N    = QW + RND;
    localparam int AMW  = AW + 1;
    localparam int BMW  = BW + 1;
    localparam int RW   = BMW + 1;
    localparam int CW   = AMW + BMW + QW + FB + 2;
    localparam int CNTW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [BMW-1:0]  rem_q, rem_d;
    logic [N-1:0]    num_q, num_d;
    logic [BMW-1:0]  div_q, div_d;
    logic            neg_q, neg_d;
    logic            dzp_q, dzp_d;
    logic            ovp_q, ovp_d;
    logic [QW-1:0]   qout_q, qout_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic            ov_q, ov_d;

    logic            a_neg, b_neg;
    logic [AMW-1:0]  a_ext, a_mag;
    logic [BMW-1:0]  b_ext, b_mag;
    logic            ovf_cmp;
    logic [RW-1:0]   sh;
    logic            qbit;
    logic            rbit;
    logic [QW:0]     mag;
    logic [QW:0]     lim;
    logic [QW-1:0]   sat_pos;
    logic            ovf_all;

    // Operand magnitudes carry one extra bit so |-2^(AW-1)| stays exact.
    always_comb begin
        a_neg   = (SGN != 0) && ain[AW-1];
        b_neg   = (SGN != 0) && bin[BW-1];
        a_ext   = {a_neg, ain};
        b_ext   = {b_neg, bin};
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        ovf_cmp = (CW'(a_mag) << FB) >= (CW'(b_mag) << (QW - SGN));
        sh      = {rem_q, num_q[N-1]};
        qbit    = sh >= RW'(div_q);
        rbit    = (RND != 0) ? num_q[0] : 1'b0;
        mag     = (QW+1)'(num_q >> RND) + (QW+1)'(rbit);
        lim     = (QW+1)'(1) << (QW - SGN);
        sat_pos = QW'(lim - (QW+1)'(1));
        ovf_all = ovp_q | dzp_q | (mag >= lim);
    end

    // Upper dividend bits seed the remainder; the rest shift in while quotient bits shift out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        num_d   = num_q;
        div_d   = div_q;
        neg_d   = neg_q;
        dzp_d   = dzp_q;
        ovp_d   = ovp_q;
        qout_d  = qout_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        ov_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (iv) begin
                    state_d = RUN;
                    cnt_d   = CNTW'(N - 1);
                    rem_d   = BMW'((CW'(a_mag) << (FB + RND)) >> N);
                    num_d   = N'(CW'(a_mag) << (FB + RND));
                    div_d   = b_mag;
                    neg_d   = a_neg ^ b_neg;
                    dzp_d   = (bin == '0);
                    ovp_d   = ovf_cmp;
                end
            end
            RUN: begin
                rem_d = qbit ? BMW'(sh - RW'(div_q)) : BMW'(sh);
                num_d = {num_q[N-2:0], qbit};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                ov_d    = 1'b1;
                dz_d    = dzp_q;
                ovf_d   = ovf_all;
                if (ovf_all) begin
                    qout_d = neg_q ? -sat_pos : sat_pos;
                end else begin
                    qout_d = neg_q ? -mag[QW-1:0] : mag[QW-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            num_q   <= '0;
            div_q   <= '0;
            neg_q   <= 1'b0;
            dzp_q   <= 1'b0;
            ovp_q   <= 1'b0;
            qout_q  <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            num_q   <= num_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            dzp_q   <= dzp_d;
            ovp_q   <= ovp_d;
            qout_q  <= qout_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            ov_q    <= ov_d;
        end
    end

    assign rdy  = (state_q == IDLE);
    assign qout = qout_q;
    assign ov   = ov_q;
    assign dz   = dz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_div_seq_q.sv
// Bench for div_seq_q: unsigned, signed and rounding instances checked against
// an arithmetic reference model with directed and random operands.
module tb_div_seq_q;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ain, bin;
    logic [2:0]  iv;
    logic [23:0] qout_a [3];
    logic        ov_a   [3];
    logic        dz_a   [3];
    logic        ovf_a  [3];
    logic        rdy_a  [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_seq_q #(.SGN(0), .RND(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .ain(ain), .bin(bin), .iv(iv[0]),
        .rdy(rdy_a[0]), .qout(qout_a[0]), .ov(ov_a[0]), .dz(dz_a[0]), .ovf(ovf_a[0])
    );

    div_seq_q #(.SGN(1), .RND(0)) u_sgn (
        .clk(clk), .rst_n(rst_n), .ain(ain), .bin(bin), .iv(iv[1]),
        .rdy(rdy_a[1]), .qout(qout_a[1]), .ov(ov_a[1]), .dz(dz_a[1]), .ovf(ovf_a[1])
    );

    div_seq_q #(.SGN(0), .RND(1)) u_rnd (
        .clk(clk), .rst_n(rst_n), .ain(ain), .bin(bin), .iv(iv[2]),
        .rdy(rdy_a[2]), .qout(qout_a[2]), .ov(ov_a[2]), .dz(dz_a[2]), .ovf(ovf_a[2])
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: instance 0 unsigned, 1 signed, 2 unsigned with rounding; QW=24, FB=23.
    function automatic void model(input int inst, input logic [15:0] a, input logic [15:0] b,
                                  output logic [23:0] q, output logic edz, output logic eovf);
        bit     sgn, rnd, neg;
        longint av, bv, ma, mb, m, lim;
        sgn = (inst == 1);
        rnd = (inst == 2);
        av  = sgn ? longint'($signed(a)) : longint'(a);
        bv  = sgn ? longint'($signed(b)) : longint'(b);
        neg = (av < 0) ^ (bv < 0);
        ma  = (av < 0) ? -av : av;
        mb  = (bv < 0) ? -bv : bv;
        lim = sgn ? (64'sd1 << 23) : (64'sd1 << 24);
        edz = (mb == 0);
        if (edz) begin
            m = lim;
        end else if (rnd) begin
            m = ((ma * (64'sd1 << 24)) / mb + 1) / 2;
        end else begin
            m = (ma * (64'sd1 << 23)) / mb;
        end
        eovf = (m >= lim);
        if (eovf) m = lim - 1;
        q = 24'(neg ? -m : m);
    endfunction

    task automatic applyStimulus(input int inst, input logic [15:0] a, input logic [15:0] b);
        int guard = 0;
        while (!rdy_a[inst] && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        ain = a;
        bin = b;
        iv[inst] = 1'b1;
        @(posedge clk); #1;
        iv[inst] = 1'b0;
        checkValue($sformatf("rdy_fall[%0d]", inst), 32'(rdy_a[inst]), 32'd0);
    endtask

    task automatic checkOutput(input int inst, input logic [15:0] a, input logic [15:0] b,
                               input int elapsed);
        int          cyc  = elapsed;
        bit          seen = 1'b0;
        int          lat  = (inst == 2) ? 26 : 25;
        logic [23:0] eq;
        logic        edz, eovf;
        while (!seen && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (ov_a[inst]) seen = 1'b1;
        end
        model(inst, a, b, eq, edz, eovf);
        checkValue($sformatf("latency[%0d] %h/%h", inst, a, b), 32'(cyc), 32'(lat));
        checkValue($sformatf("rdy_back[%0d]", inst), 32'(rdy_a[inst]), 32'd1);
        checkValue($sformatf("qout[%0d] %h/%h", inst, a, b), 32'(qout_a[inst]), 32'(eq));
        checkValue($sformatf("dz[%0d] %h/%h", inst, a, b), 32'(dz_a[inst]), 32'(edz));
        checkValue($sformatf("ovf[%0d] %h/%h", inst, a, b), 32'(ovf_a[inst]), 32'(eovf));
        @(posedge clk); #1;
        checkValue($sformatf("ov_single[%0d]", inst), 32'(ov_a[inst]), 32'd0);
        checkValue($sformatf("qout_hold[%0d]", inst), 32'(qout_a[inst]), 32'(eq));
    endtask

    task automatic runOp(input int inst, input logic [15:0] a, input logic [15:0] b);
        applyStimulus(inst, a, b);
        checkOutput(inst, a, b, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int          ov_count;
        rst_n = 1'b0;
        iv    = '0;
        ain   = '0;
        bin   = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checkValue($sformatf("reset_rdy[%0d]", i), 32'(rdy_a[i]), 32'd1);
            checkValue($sformatf("reset_qout[%0d]", i), 32'(qout_a[i]), 32'd0);
            checkValue($sformatf("reset_ov[%0d]", i), 32'(ov_a[i]), 32'd0);
            checkValue($sformatf("reset_flags[%0d]", i), 32'({dz_a[i], ovf_a[i]}), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] unsigned directed operations");
        for (int k = 0; k < 8; k++) runOp(0, 16'hB504, 16'hB04F + 16'(k));
        runOp(0, 16'h4000, 16'h8000);
        runOp(0, 16'hFFFF, 16'h0001);
        runOp(0, 16'h1234, 16'h0000);
        runOp(0, 16'h0001, 16'h0003);
        runOp(0, 16'h0000, 16'h0005);

        $display("[TB] signed directed operations");
        runOp(1, 16'hE000, 16'h4000);
        runOp(1, 16'hC000, 16'h4000);
        runOp(1, 16'h8000, 16'hFFFF);
        runOp(1, 16'h0000, 16'h0000);
        runOp(1, 16'h8000, 16'h0000);
        runOp(1, 16'h2000, 16'hC000);

        $display("[TB] rounding directed operations");
        runOp(2, 16'h0001, 16'h0003);
        runOp(2, 16'hB504, 16'hB04F);
        runOp(2, 16'hFFFF, 16'hFFFF);

        $display("[TB] random operations");
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 8; k++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                runOp(i, ra, rb);
            end
        end

        $display("[TB] iv while busy is dropped");
        applyStimulus(0, 16'h3000, 16'h7000);
        repeat (2) begin @(posedge clk); #1; end
        ain = 16'h0001; bin = 16'h0002; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        checkValue("busy_rdy_c3", 32'(rdy_a[0]), 32'd0);
        repeat (6) begin @(posedge clk); #1; end
        ain = 16'hFFFF; bin = 16'h0000; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        checkValue("busy_rdy_c10", 32'(rdy_a[0]), 32'd0);
        checkOutput(0, 16'h3000, 16'h7000, 10);
        repeat (30) begin @(posedge clk); #1; end
        checkValue("no_second_ov", 32'(ov_a[0]), 32'd0);

        $display("[TB] reset during RUN");
        applyStimulus(0, 16'h5555, 16'h6000);
        repeat (12) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checkValue("midrst_rdy", 32'(rdy_a[0]), 32'd1);
        checkValue("midrst_qout", 32'(qout_a[0]), 32'd0);
        checkValue("midrst_ov", 32'(ov_a[0]), 32'd0);
        checkValue("midrst_flags", 32'({dz_a[0], ovf_a[0]}), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ov_count = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ov_a[0]) ov_count++;
        end
        checkValue("midrst_no_ov", 32'(ov_count), 32'd0);
        runOp(0, 16'h4000, 16'h8000);
        runOp(0, 16'h5555, 16'h6000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
